// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one SRAM fetch per cycle and presents the returned
// word to ID, holding it in a one-entry buffer while ID stalls and dropping it on a redirect.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h1BFF_FFFC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        id_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  logic [31:0] r_fs_pc;
  logic        r_fs_valid;
  logic [31:0] r_inst_buf;
  logic        r_inst_buf_valid;
  logic        r_to_fs_valid;

  logic [31:0] w_nextpc;
  logic        w_fs_allowin;
  logic        w_fetch;
  logic        w_stall_capture;

  assign w_nextpc     = br_taken ? br_target : (r_fs_pc + 32'd4);
  assign w_fs_allowin = !r_fs_valid | (id_allowin & !br_taken) | br_taken;
  assign w_fetch      = r_to_fs_valid & w_fs_allowin;

  // The SRAM word is only valid in the cycle right after its request, so a stalled
  // instruction must be latched at the first stalled edge.
  assign w_stall_capture = r_fs_valid & !r_inst_buf_valid & !id_allowin & !br_taken;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fs_pc          <= PC_RESET;
      r_fs_valid       <= 1'b0;
      r_inst_buf       <= 32'd0;
      r_inst_buf_valid <= 1'b0;
      r_to_fs_valid    <= 1'b0;
    end else begin
      r_to_fs_valid <= 1'b1;
      if (w_fetch) begin
        r_fs_pc          <= w_nextpc;
        r_fs_valid       <= 1'b1;
        r_inst_buf_valid <= 1'b0;
      end else if (w_stall_capture) begin
        r_inst_buf       <= inst_sram_rdata;
        r_inst_buf_valid <= 1'b1;
      end
    end
  end

  assign inst_sram_en    = w_fetch;
  assign inst_sram_we    = 4'd0;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_wdata = 32'd0;

  // A redirect in flight means the current word is wrong-path; never offer it.
  assign fs_to_ds_valid = r_fs_valid & !br_taken;
  assign id_pc          = r_fs_pc;
  assign id_inst        = r_inst_buf_valid ? r_inst_buf : inst_sram_rdata;

endmodule
